// File: rtl/zcmt_dcache_arbiter.sv
// Shares one read-only dcache load port between the load unit (ID 0) and the ZCMT
// table-fetch engine (ID 1). Optional ZCMT anti-starvation priority: ZCMT_ARB_STARVE_EN.
module zcmt_dcache_arbiter #(
  parameter int unsigned IDX_W        = 12,
  parameter int unsigned TAG_W        = 22,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ID_W         = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_req_i,
  input  logic [IDX_W-1:0] ld_index_i,
  input  logic [TAG_W-1:0] ld_tag_i,
  input  logic [1:0]       ld_size_i,
  input  logic             ld_kill_i,
  input  logic             zt_req_i,
  input  logic [IDX_W-1:0] zt_index_i,
  input  logic [TAG_W-1:0] zt_tag_i,
  input  logic [1:0]       zt_size_i,
  input  logic             zt_kill_i,
  output logic             ld_gnt_o,
  output logic             zt_gnt_o,
  output logic             ld_rvalid_o,
  output logic             zt_rvalid_o,
  output logic [XLEN-1:0]  ld_rdata_o,
  output logic [XLEN-1:0]  zt_rdata_o,
  output logic             dc_req_o,
  output logic [IDX_W-1:0] dc_index_o,
  output logic [1:0]       dc_size_o,
  output logic [ID_W-1:0]  dc_id_o,
  output logic [TAG_W-1:0] dc_tag_o,
  output logic             dc_tag_valid_o,
  output logic             dc_kill_o,
  input  logic             dc_gnt_i,
  input  logic             dc_rvalid_i,
  input  logic [ID_W-1:0]  dc_rid_i,
  input  logic [XLEN-1:0]  dc_rdata_i
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    TAG         = 2'd2,
    WAIT_RVALID = 2'd3
  } state_e;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be in 1..255");
  end

  state_e state_r, state_s;
  logic   owner_r, owner_s;     // 0 = load unit, 1 = ZCMT
  logic   abort_r, abort_s;     // kill raced a grant: TAG slot becomes an abort
  logic   any_req_s;
  logic   winner_s;
  logic   zt_first_s;
  logic   sel_s;
  logic   own_req_s;
  logic   own_kill_s;
  logic   gnt_fwd_s;
  logic   rvalid_fwd_s;

  assign any_req_s  = ld_req_i | zt_req_i;
  assign winner_s   = zt_req_i & (zt_first_s | ~ld_req_i);
  assign sel_s      = (state_r == IDLE) ? winner_s : owner_r;
  assign own_req_s  = owner_r ? zt_req_i  : ld_req_i;
  assign own_kill_s = owner_r ? zt_kill_i : ld_kill_i;

`ifdef ZCMT_ARB_STARVE_EN
  logic [7:0] starve_cnt_r;
  logic       zt_owner_s;

  assign zt_owner_s = (state_r == IDLE) ? (any_req_s & winner_s) : owner_r;
  assign zt_first_s = (starve_cnt_r >= 8'(STARVE_LIMIT));

  // Saturating count of cycles the ZCMT requester waits while not owning the port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_r <= 8'd0;
    end else if (zt_gnt_o) begin
      starve_cnt_r <= 8'd0;
    end else if (zt_req_i && !zt_owner_s && (starve_cnt_r != 8'hFF)) begin
      starve_cnt_r <= starve_cnt_r + 8'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  assign zt_first_s = 1'b0;
`endif

  // State, owner and abort-flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      abort_r <= abort_s;
    end
  end

  // Next-state logic and dcache-side outputs.
  always_comb begin
    state_s        = state_r;
    owner_s        = owner_r;
    abort_s        = 1'b0;
    dc_req_o       = 1'b0;
    dc_index_o     = {IDX_W{1'b0}};
    dc_size_o      = 2'b00;
    dc_id_o        = {ID_W{1'b0}};
    dc_tag_o       = {TAG_W{1'b0}};
    dc_tag_valid_o = 1'b0;
    dc_kill_o      = 1'b0;
    gnt_fwd_s      = 1'b0;
    rvalid_fwd_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          dc_req_o  = 1'b1;
          owner_s   = winner_s;
          gnt_fwd_s = dc_gnt_i;
          state_s   = dc_gnt_i ? TAG : WAIT_GNT;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_GNT: begin
        if (own_kill_s) begin
          // A grant in the same cycle still opens a transaction in the cache; abort it in TAG.
          if (dc_gnt_i && own_req_s) begin
            abort_s = 1'b1;
            state_s = TAG;
          end else begin
            state_s = IDLE;
          end
        end else if (!own_req_s) begin
          state_s = IDLE;
        end else begin
          dc_req_o  = 1'b1;
          gnt_fwd_s = dc_gnt_i;
          state_s   = dc_gnt_i ? TAG : WAIT_GNT;
        end
      end
      TAG: begin
        if (abort_r) begin
          dc_kill_o = 1'b1;
          state_s   = IDLE;
        end else begin
          dc_tag_o       = owner_r ? zt_tag_i : ld_tag_i;
          dc_tag_valid_o = 1'b1;
          dc_kill_o      = own_kill_s;
          state_s        = own_kill_s ? IDLE : WAIT_RVALID;
        end
      end
      WAIT_RVALID: begin
        if (own_kill_s) begin
          dc_kill_o = 1'b1;
          state_s   = IDLE;
        end else if (dc_rvalid_i && (dc_rid_i == ID_W'(owner_r))) begin
          rvalid_fwd_s = 1'b1;
          state_s      = IDLE;
        end else begin
          state_s = WAIT_RVALID;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (dc_req_o) begin
      dc_index_o = sel_s ? zt_index_i : ld_index_i;
      dc_size_o  = sel_s ? zt_size_i  : ld_size_i;
      dc_id_o    = ID_W'(sel_s);
    end else begin
      dc_index_o = {IDX_W{1'b0}};
      dc_size_o  = 2'b00;
      dc_id_o    = {ID_W{1'b0}};
    end
  end

  assign ld_gnt_o    = gnt_fwd_s & ~sel_s;
  assign zt_gnt_o    = gnt_fwd_s & sel_s;
  assign ld_rvalid_o = rvalid_fwd_s & ~owner_r;
  assign zt_rvalid_o = rvalid_fwd_s & owner_r;
  assign ld_rdata_o  = ld_rvalid_o ? dc_rdata_i : {XLEN{1'b0}};
  assign zt_rdata_o  = zt_rvalid_o ? dc_rdata_i : {XLEN{1'b0}};

endmodule

// File: tb/tb_zcmt_dcache_arbiter.sv
// Self-checking bench for zcmt_dcache_arbiter: directed steps from the test plan, then
// randomized traffic, all checked against a transaction-level model of the arbiter.
module tb_zcmt_dcache_arbiter;
  localparam int IDX_W        = 12;
  localparam int TAG_W        = 22;
  localparam int XLEN         = 32;
  localparam int ID_W         = 2;
  localparam int STARVE_LIMIT = 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic ld_req_i, zt_req_i, ld_kill_i, zt_kill_i;
  logic [IDX_W-1:0] ld_index_i, zt_index_i;
  logic [TAG_W-1:0] ld_tag_i, zt_tag_i;
  logic [1:0] ld_size_i, zt_size_i;
  logic ld_gnt_o, zt_gnt_o, ld_rvalid_o, zt_rvalid_o;
  logic [XLEN-1:0] ld_rdata_o, zt_rdata_o;
  logic dc_req_o, dc_tag_valid_o, dc_kill_o;
  logic [IDX_W-1:0] dc_index_o;
  logic [1:0] dc_size_o;
  logic [ID_W-1:0] dc_id_o;
  logic [TAG_W-1:0] dc_tag_o;
  logic dc_gnt_i, dc_rvalid_i;
  logic [ID_W-1:0] dc_rid_i;
  logic [XLEN-1:0] dc_rdata_i;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: is a transaction open, who owns it, how far it has got.
  bit m_busy, m_who, m_granted, m_tagged, m_doomed;
  bit n_busy, n_who, n_granted, n_tagged, n_doomed;
  int m_starve, n_starve;

  zcmt_dcache_arbiter #(
    .IDX_W(IDX_W), .TAG_W(TAG_W), .XLEN(XLEN), .ID_W(ID_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ld_req_i(ld_req_i), .ld_index_i(ld_index_i), .ld_tag_i(ld_tag_i),
    .ld_size_i(ld_size_i), .ld_kill_i(ld_kill_i),
    .zt_req_i(zt_req_i), .zt_index_i(zt_index_i), .zt_tag_i(zt_tag_i),
    .zt_size_i(zt_size_i), .zt_kill_i(zt_kill_i),
    .ld_gnt_o(ld_gnt_o), .zt_gnt_o(zt_gnt_o), .ld_rvalid_o(ld_rvalid_o),
    .zt_rvalid_o(zt_rvalid_o), .ld_rdata_o(ld_rdata_o), .zt_rdata_o(zt_rdata_o),
    .dc_req_o(dc_req_o), .dc_index_o(dc_index_o), .dc_size_o(dc_size_o),
    .dc_id_o(dc_id_o), .dc_tag_o(dc_tag_o), .dc_tag_valid_o(dc_tag_valid_o),
    .dc_kill_o(dc_kill_o), .dc_gnt_i(dc_gnt_i), .dc_rvalid_i(dc_rvalid_i),
    .dc_rid_i(dc_rid_i), .dc_rdata_i(dc_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    ld_req_i = 1'b0; zt_req_i = 1'b0; ld_kill_i = 1'b0; zt_kill_i = 1'b0;
    ld_index_i = '0; zt_index_i = '0; ld_tag_i = '0; zt_tag_i = '0;
    ld_size_i = 2'b00; zt_size_i = 2'b00;
    dc_gnt_i = 1'b0; dc_rvalid_i = 1'b0; dc_rid_i = '0; dc_rdata_i = '0;
  endtask

  // Mid-cycle: derive expected outputs from the model and compare every output.
  task automatic settle();
    bit any, win, oreq, okill, zt_pri, zt_owner;
    bit e_req, e_tagv, e_kill;
    bit [1:0] e_gnt, e_rv;
    logic [IDX_W-1:0] e_index;
    logic [1:0] e_size;
    logic [ID_W-1:0] e_id;
    logic [TAG_W-1:0] e_tag;
    logic [XLEN-1:0] e_ldd, e_ztd;
    #2;
    e_req = 1'b0; e_tagv = 1'b0; e_kill = 1'b0; e_gnt = 2'b00; e_rv = 2'b00;
    e_index = '0; e_size = 2'b00; e_id = '0; e_tag = '0; e_ldd = '0; e_ztd = '0;
    n_busy = m_busy; n_who = m_who; n_granted = m_granted; n_tagged = m_tagged;
    n_doomed = m_doomed;
    zt_pri = 1'b0;
`ifdef ZCMT_ARB_STARVE_EN
    zt_pri = (m_starve >= STARVE_LIMIT);
`endif
    any   = ld_req_i | zt_req_i;
    win   = zt_req_i && (zt_pri || !ld_req_i);
    oreq  = m_who ? zt_req_i : ld_req_i;
    okill = m_who ? zt_kill_i : ld_kill_i;
    if (!m_busy) begin
      if (any) begin
        e_req = 1'b1; e_id = ID_W'(win);
        e_index = win ? zt_index_i : ld_index_i;
        e_size  = win ? zt_size_i : ld_size_i;
        e_gnt[win] = dc_gnt_i;
        n_busy = 1'b1; n_who = win; n_granted = dc_gnt_i; n_tagged = 1'b0; n_doomed = 1'b0;
      end
    end else if (!m_granted) begin
      if (okill) begin
        if (dc_gnt_i && oreq) begin n_granted = 1'b1; n_doomed = 1'b1; end
        else n_busy = 1'b0;
      end else if (!oreq) begin
        n_busy = 1'b0;
      end else begin
        e_req = 1'b1; e_id = ID_W'(m_who);
        e_index = m_who ? zt_index_i : ld_index_i;
        e_size  = m_who ? zt_size_i : ld_size_i;
        if (dc_gnt_i) begin e_gnt[m_who] = 1'b1; n_granted = 1'b1; end
      end
    end else if (!m_tagged) begin
      if (m_doomed) begin
        e_kill = 1'b1; n_busy = 1'b0;
      end else begin
        e_tagv = 1'b1; e_tag = m_who ? zt_tag_i : ld_tag_i;
        if (okill) begin e_kill = 1'b1; n_busy = 1'b0; end
        else n_tagged = 1'b1;
      end
    end else begin
      if (okill) begin
        e_kill = 1'b1; n_busy = 1'b0;
      end else if (dc_rvalid_i && (int'(dc_rid_i) == int'(m_who))) begin
        e_rv[m_who] = 1'b1;
        if (m_who) e_ztd = dc_rdata_i; else e_ldd = dc_rdata_i;
        n_busy = 1'b0;
      end
    end
    zt_owner = m_busy ? m_who : (any && win);
    if (e_gnt[1]) n_starve = 0;
    else if (zt_req_i && !zt_owner && m_starve < 255) n_starve = m_starve + 1;
    else n_starve = m_starve;
    chk("dc_req", 64'(dc_req_o), 64'(e_req));
    chk("dc_index", 64'(dc_index_o), 64'(e_index));
    chk("dc_size", 64'(dc_size_o), 64'(e_size));
    chk("dc_id", 64'(dc_id_o), 64'(e_id));
    chk("dc_tag", 64'(dc_tag_o), 64'(e_tag));
    chk("dc_tag_valid", 64'(dc_tag_valid_o), 64'(e_tagv));
    chk("dc_kill", 64'(dc_kill_o), 64'(e_kill));
    chk("ld_gnt", 64'(ld_gnt_o), 64'(e_gnt[0]));
    chk("zt_gnt", 64'(zt_gnt_o), 64'(e_gnt[1]));
    chk("ld_rvalid", 64'(ld_rvalid_o), 64'(e_rv[0]));
    chk("zt_rvalid", 64'(zt_rvalid_o), 64'(e_rv[1]));
    chk("ld_rdata", 64'(ld_rdata_o), 64'(e_ldd));
    chk("zt_rdata", 64'(zt_rdata_o), 64'(e_ztd));
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
    m_busy = n_busy; m_who = n_who; m_granted = n_granted; m_tagged = n_tagged;
    m_doomed = n_doomed; m_starve = n_starve;
  endtask

  initial begin
    logic [TAG_W-1:0] tag_v;
    logic [XLEN-1:0] data_v;
    int zt_wins, first_win;
    m_busy = 1'b0; m_who = 1'b0; m_granted = 1'b0; m_tagged = 1'b0; m_doomed = 1'b0;
    m_starve = 0;
    zero_inputs();
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    settle(); advance();
    settle();
    chk("reset_dc_req", 64'(dc_req_o), 64'd0);
    chk("reset_ld_gnt", 64'(ld_gnt_o), 64'd0);
    rst_ni = 1'b1;
    advance();

    // Load only, immediate grant, response two cycles later.
    ld_req_i = 1'b1; ld_index_i = 12'h010; ld_size_i = 2'b10; dc_gnt_i = 1'b1;
    settle();
    chk("t1_ld_gnt", 64'(ld_gnt_o), 64'd1);
    chk("t1_index", 64'(dc_index_o), 64'h010);
    advance();
    ld_req_i = 1'b0; dc_gnt_i = 1'b0; ld_tag_i = 22'h2ABCDE;
    settle();
    chk("t1_tag_valid", 64'(dc_tag_valid_o), 64'd1);
    chk("t1_tag", 64'(dc_tag_o), 64'h2ABCDE);
    advance();
    dc_rvalid_i = 1'b1; dc_rid_i = 2'd0; dc_rdata_i = 32'hDEADBEEF;
    settle();
    chk("t1_ld_rvalid", 64'(ld_rvalid_o), 64'd1);
    chk("t1_ld_rdata", 64'(ld_rdata_o), 64'hDEADBEEF);
    chk("t1_zt_rvalid", 64'(zt_rvalid_o), 64'd0);
    advance();
    zero_inputs();

    // Both request together: load first, ZCMT only after one IDLE cycle.
    ld_req_i = 1'b1; zt_req_i = 1'b1; ld_index_i = 12'h123; zt_index_i = 12'h456;
    dc_gnt_i = 1'b1;
    settle();
    chk("t2_id_ld", 64'(dc_id_o), 64'd0);
    chk("t2_ld_gnt", 64'(ld_gnt_o), 64'd1);
    chk("t2_zt_gnt0", 64'(zt_gnt_o), 64'd0);
    advance();
    ld_req_i = 1'b0;
    settle();
    chk("t2_zt_gnt_tag", 64'(zt_gnt_o), 64'd0);
    advance();
    dc_rvalid_i = 1'b1; dc_rid_i = 2'd0; dc_rdata_i = 32'h0BADF00D;
    settle();
    chk("t2_ld_rvalid", 64'(ld_rvalid_o), 64'd1);
    chk("t2_zt_gnt_rv", 64'(zt_gnt_o), 64'd0);
    advance();
    dc_rvalid_i = 1'b0;
    settle();
    chk("t2_id_zt", 64'(dc_id_o), 64'd1);
    chk("t2_zt_gnt", 64'(zt_gnt_o), 64'd1);
    advance();
    zt_req_i = 1'b0; dc_gnt_i = 1'b0; zt_tag_i = 22'h155555;
    settle(); advance();
    dc_rvalid_i = 1'b1; dc_rid_i = 2'd1; dc_rdata_i = 32'hCAFE0001;
    settle();
    chk("t2_zt_rdata", 64'(zt_rdata_o), 64'hCAFE0001);
    advance();
    zero_inputs();

    // ZCMT owns, grant delayed three cycles while load also requests.
    zt_req_i = 1'b1; zt_index_i = 12'h3A5; zt_size_i = 2'b01;
    settle(); advance();
    ld_req_i = 1'b1; ld_index_i = 12'h0F0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_req_held", 64'(dc_req_o), 64'd1);
      chk("t3_index", 64'(dc_index_o), 64'h3A5);
      chk("t3_id", 64'(dc_id_o), 64'd1);
      advance();
    end
    dc_gnt_i = 1'b1;
    settle();
    chk("t3_zt_gnt", 64'(zt_gnt_o), 64'd1);
    chk("t3_ld_gnt", 64'(ld_gnt_o), 64'd0);
    advance();
    zt_req_i = 1'b0; dc_gnt_i = 1'b0; zt_tag_i = 22'h0C0FFE;
    settle(); advance();
    // Kill coincident with a matching response: kill wins.
    zt_kill_i = 1'b1; dc_rvalid_i = 1'b1; dc_rid_i = 2'd1; dc_rdata_i = 32'h12345678;
    settle();
    chk("t4_kill", 64'(dc_kill_o), 64'd1);
    chk("t4_zt_rvalid", 64'(zt_rvalid_o), 64'd0);
    advance();
    zt_kill_i = 1'b0; dc_rvalid_i = 1'b0; dc_gnt_i = 1'b1;
    settle();
    chk("t4_idle_again", 64'(ld_gnt_o), 64'd1);
    advance();
    ld_req_i = 1'b0; dc_gnt_i = 1'b0; ld_tag_i = 22'h000777;
    settle(); advance();
    // Mismatched response id is ignored.
    dc_rvalid_i = 1'b1; dc_rid_i = 2'd1; dc_rdata_i = 32'h55AA55AA;
    settle();
    chk("t5_ld_rv0", 64'(ld_rvalid_o), 64'd0);
    chk("t5_zt_rv0", 64'(zt_rvalid_o), 64'd0);
    advance();
    dc_rid_i = 2'd0; dc_rdata_i = 32'hA5A5A5A5;
    settle();
    chk("t5_ld_rv1", 64'(ld_rvalid_o), 64'd1);
    advance();
    zero_inputs();

    // Both requesters continuous, dcache always ready, responses tagged for load.
    zt_wins = 0; first_win = -1;
    ld_req_i = 1'b1; zt_req_i = 1'b1; dc_gnt_i = 1'b1; dc_rvalid_i = 1'b1; dc_rid_i = 2'd0;
    for (int c = 0; c < 24; c++) begin
      settle();
      if (zt_gnt_o === 1'b1) begin
        zt_wins++;
        if (first_win < 0) first_win = c;
      end
      advance();
    end
`ifdef ZCMT_ARB_STARVE_EN
    chk("t6_zt_wins", 64'(first_win >= 0 && first_win <= STARVE_LIMIT + 3), 64'd1);
`else
    chk("t6_zt_never", 64'(zt_wins), 64'd0);
`endif
    zero_inputs();

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 600; c++) begin
      ld_req_i    = ($urandom_range(0, 2) != 0);
      zt_req_i    = ($urandom_range(0, 2) != 0);
      ld_kill_i   = ($urandom_range(0, 9) == 0);
      zt_kill_i   = ($urandom_range(0, 9) == 0);
      ld_index_i  = IDX_W'($urandom);
      zt_index_i  = IDX_W'($urandom);
      ld_size_i   = 2'($urandom);
      zt_size_i   = 2'($urandom);
      tag_v       = TAG_W'($urandom);
      ld_tag_i    = tag_v;
      zt_tag_i    = ~tag_v;
      dc_gnt_i    = ($urandom_range(0, 1) != 0);
      dc_rvalid_i = ($urandom_range(0, 1) != 0);
      dc_rid_i    = ID_W'($urandom_range(0, 3));
      data_v      = $urandom;
      dc_rdata_i  = data_v;
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
